// File: rtl/interframe_overload_ctrl.sv
// interframe_overload_ctrl: CAN/CAN-FD bus integration, intermission, suspend and overload-frame sequencer
module interframe_overload_ctrl #(
  parameter int IDLE_BITS        = 11,
  parameter int INTERMISSION_LEN = 3,
  parameter int SUSPEND_LEN      = 8,
  parameter int OVL_FLAG_LEN     = 6,
  parameter int OVL_DELIM_LEN    = 8,
  parameter int DOM_LIMIT        = 7,
  parameter int MAX_OVERLOAD     = 2
) (
  input  logic       samplePoint,
  input  logic       reset,
  input  logic       canRX,
  input  logic       frameReady,
  input  logic       isError,
  input  logic       errorEnd,
  input  logic       requestOverload,
  input  logic       errorPassive,
  input  logic       wasTransmitter,
  output logic       isStart,
  output logic       busIdle,
  output logic       overloadDrive,
  output logic       endOverload,
  output logic       formError,
  output logic [3:0] overloadCount
);
  typedef enum logic [3:0] {
    INTEGRATE, IDLE, FRAME, ERR_WAIT, INTERMISSION, SUSPEND, OVL_FLAG, OVL_WAIT, OVL_DELIM
  } stateT;
  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_BITS - 1);
  localparam logic [7:0] INT_LAST   = 8'(INTERMISSION_LEN - 1);
  localparam logic [7:0] SUSP_LAST  = 8'(SUSPEND_LEN - 1);
  localparam logic [7:0] FLAG_LAST  = 8'(OVL_FLAG_LEN - 1);
  localparam logic [7:0] DOM_MAX    = 8'(DOM_LIMIT);
  localparam logic [7:0] DELIM_LAST = 8'(OVL_DELIM_LEN - 1);
  localparam logic [3:0] OVL_MAX    = 4'(MAX_OVERLOAD);
  stateT state, nState;
  logic [7:0] cnt, nCnt;
  logic [3:0] nOvl;
  logic nStart, nEnd, nFerr, ovlCond;
  // cnt is shared: recessive run, intermission/suspend bit index, flag length, dominant run, delimCnt
  assign ovlCond = (!canRX && cnt < INT_LAST) || (requestOverload && cnt == '0);
  always_comb begin
    nState = state;
    nCnt = cnt;
    nOvl = overloadCount;
    nStart = 1'b0;
    nEnd = 1'b0;
    nFerr = 1'b0;
    case (state)
      INTEGRATE: begin
        nCnt = canRX ? cnt + 8'd1 : '0;
        if (canRX && cnt == IDLE_LAST) begin nState = IDLE; nCnt = '0; end
      end
      IDLE: if (!canRX) begin nState = FRAME; nStart = 1'b1; end
      FRAME: if (frameReady) begin nState = INTERMISSION; nCnt = '0; end
      ERR_WAIT: if (errorEnd) begin nState = INTERMISSION; nCnt = '0; end
      INTERMISSION: begin
        nCnt = cnt + 8'd1;
        if (ovlCond) begin
          nState = overloadCount < OVL_MAX ? OVL_FLAG : ERR_WAIT;
          nFerr = overloadCount >= OVL_MAX;
          nCnt = '0;
        end else if (cnt == INT_LAST) begin
          nState = !canRX ? FRAME : (errorPassive && wasTransmitter) ? SUSPEND : IDLE;
          nStart = !canRX;
          nCnt = '0;
        end
      end
      SUSPEND: begin
        nCnt = cnt + 8'd1;
        if (!canRX) begin nState = FRAME; nStart = 1'b1; nCnt = '0; end
        else if (cnt == SUSP_LAST) begin nState = IDLE; nCnt = '0; end
      end
      OVL_FLAG: begin
        nCnt = cnt + 8'd1;
        if (cnt == FLAG_LAST) begin nState = OVL_WAIT; nCnt = '0; end
      end
      OVL_WAIT: begin
        nCnt = cnt + 8'd1;
        if (canRX) begin nState = OVL_DELIM; nCnt = 8'd1; end
        else if (cnt == DOM_MAX) begin nState = ERR_WAIT; nFerr = 1'b1; nCnt = '0; end
      end
      OVL_DELIM: begin
        nCnt = cnt + 8'd1;
        if (!canRX) begin nState = ERR_WAIT; nFerr = 1'b1; nCnt = '0; end
        else if (cnt == DELIM_LAST) begin
          nState = INTERMISSION;
          nEnd = 1'b1;
          nOvl = overloadCount == 4'hF ? 4'hF : overloadCount + 4'd1;
          nCnt = '0;
        end
      end
      default: begin nState = INTEGRATE; nCnt = '0; end
    endcase
    // an error frame overrides everything the bus-level logic decided this bit
    if (isError && state != INTEGRATE) begin
      nState = ERR_WAIT;
      nCnt = '0;
      nOvl = overloadCount;
      nStart = 1'b0;
      nEnd = 1'b0;
      nFerr = 1'b0;
    end
    if (nStart || (nState == IDLE && state != IDLE)) nOvl = '0;
  end
  always_ff @(posedge samplePoint) begin
    if (reset) begin
      state <= INTEGRATE;
      cnt <= '0;
      overloadCount <= '0;
      isStart <= 1'b0;
      busIdle <= 1'b0;
      overloadDrive <= 1'b0;
      endOverload <= 1'b0;
      formError <= 1'b0;
    end else begin
      state <= nState;
      cnt <= nCnt;
      overloadCount <= nOvl;
      isStart <= nStart;
      busIdle <= nState == IDLE;
      overloadDrive <= nState == OVL_FLAG;
      endOverload <= nEnd;
      formError <= nFerr;
    end
  end
endmodule

// File: tb/tb_interframe_overload_ctrl.sv
// tb_interframe_overload_ctrl: directed scenarios plus randomized bus traffic against a phase-level model
module tb_interframe_overload_ctrl;
  localparam int IDLE_BITS = 11, INTERMISSION_LEN = 3, SUSPEND_LEN = 8, OVL_FLAG_LEN = 6;
  localparam int OVL_DELIM_LEN = 8, DOM_LIMIT = 7, MAX_OVERLOAD = 2;
  localparam int M_INTEG = 0, M_IDLE = 1, M_FRAME = 2, M_ERR = 3, M_INTER = 4;
  localparam int M_SUSP = 5, M_FLAG = 6, M_WAIT = 7, M_DELIM = 8;
  logic samplePoint = 1'b0;
  logic reset = 1'b0, canRX = 1'b1, frameReady = 1'b0, isError = 1'b0, errorEnd = 1'b0;
  logic requestOverload = 1'b0, errorPassive = 1'b0, wasTransmitter = 1'b0;
  logic isStart, busIdle, overloadDrive, endOverload, formError;
  logic [3:0] overloadCount;
  logic [8:0] obs, exp;
  int vectors = 0, miscompares = 0;
  int mMode = M_INTEG, mRun = 0, mBits = 0, mFlagLeft = 0, mDom = 0, mDelim = 0, mOvl = 0;
  bit mStart, mEnd, mFerr;

  interframe_overload_ctrl dut (
    .samplePoint(samplePoint), .reset(reset), .canRX(canRX), .frameReady(frameReady),
    .isError(isError), .errorEnd(errorEnd), .requestOverload(requestOverload),
    .errorPassive(errorPassive), .wasTransmitter(wasTransmitter), .isStart(isStart),
    .busIdle(busIdle), .overloadDrive(overloadDrive), .endOverload(endOverload),
    .formError(formError), .overloadCount(overloadCount)
  );

  always #5 samplePoint = ~samplePoint;
  assign obs = {isStart, busIdle, overloadDrive, endOverload, formError, overloadCount};

  task automatic enter(input int m);
    if (m == M_IDLE) mOvl = 0;
    mMode = m;
    mRun = 0;
    mBits = 0;
    mFlagLeft = OVL_FLAG_LEN;
    mDom = 0;
    mDelim = 0;
  endtask

  task automatic modelStep();
    mStart = 0;
    mEnd = 0;
    mFerr = 0;
    if (reset) begin
      enter(M_INTEG);
      mOvl = 0;
    end else if (isError && mMode != M_INTEG) enter(M_ERR);
    else case (mMode)
      M_INTEG: begin
        mRun = canRX ? mRun + 1 : 0;
        if (mRun == IDLE_BITS) enter(M_IDLE);
      end
      M_IDLE: if (!canRX) begin mStart = 1; enter(M_FRAME); end
      M_FRAME: if (frameReady) enter(M_INTER);
      M_ERR: if (errorEnd) enter(M_INTER);
      M_INTER:
        if ((!canRX && mBits < INTERMISSION_LEN - 1) || (requestOverload && mBits == 0)) begin
          if (mOvl < MAX_OVERLOAD) enter(M_FLAG);
          else begin mFerr = 1; enter(M_ERR); end
        end else if (!canRX) begin mStart = 1; enter(M_FRAME); end
        else begin
          mBits++;
          if (mBits == INTERMISSION_LEN) enter((errorPassive && wasTransmitter) ? M_SUSP : M_IDLE);
        end
      M_SUSP:
        if (!canRX) begin mStart = 1; enter(M_FRAME); end
        else begin mBits++; if (mBits == SUSPEND_LEN) enter(M_IDLE); end
      M_FLAG: begin mFlagLeft--; if (mFlagLeft == 0) enter(M_WAIT); end
      M_WAIT:
        if (canRX) begin enter(M_DELIM); mDelim = 1; end
        else begin mDom++; if (mDom > DOM_LIMIT) begin mFerr = 1; enter(M_ERR); end end
      M_DELIM:
        if (!canRX) begin mFerr = 1; enter(M_ERR); end
        else begin
          mDelim++;
          if (mDelim == OVL_DELIM_LEN) begin
            mEnd = 1;
            mOvl = mOvl < 15 ? mOvl + 1 : 15;
            enter(M_INTER);
          end
        end
      default: enter(M_INTEG);
    endcase
    if (mStart) mOvl = 0;
    exp = {mStart, mMode == M_IDLE, mMode == M_FLAG, mEnd, mFerr, 4'(mOvl)};
  endtask

  task automatic tick(input bit rx, input bit fr = 0, input bit er = 0, input bit ee = 0, input bit ro = 0);
    canRX = rx;
    frameReady = fr;
    isError = er;
    errorEnd = ee;
    requestOverload = ro;
    @(posedge samplePoint);
    #1;
    modelStep();
  endtask

  task automatic test_reset();
    reset = 1;
    tick(1);
    vectors++; if (obs !== 9'b0) begin miscompares++; $display("FAIL reset_outputs: got %b want 000000000", obs); end
    tick(0);
    vectors++; if (obs !== exp) begin miscompares++; $display("FAIL reset_model: got %b want %b", obs, exp); end
    reset = 0;
  endtask

  task automatic test_integrate();
    for (int i = 1; i <= 22; i++) begin
      tick(i != 11);
      vectors++; if (busIdle !== (i == 22)) begin miscompares++; $display("FAIL t1_busIdle edge=%0d: got %b want %b", i, busIdle, i == 22); end
      vectors++; if (obs !== exp) begin miscompares++; $display("FAIL t1_model edge=%0d: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_sof_idle();
    tick(0);
    vectors++; if (isStart !== 1'b1 || busIdle !== 1'b0) begin miscompares++; $display("FAIL t2_sof: got start=%b idle=%b want 1 0", isStart, busIdle); end
    tick(1);
    vectors++; if (isStart !== 1'b0) begin miscompares++; $display("FAIL t2_sof_pulse: got %b want 0", isStart); end
    tick(1, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vectors++; if (busIdle !== (i == 2)) begin miscompares++; $display("FAIL t2_idle bit=%0d: got %b want %b", i, busIdle, i == 2); end
    end
  endtask

  task automatic test_overload();
    tick(0); tick(1); tick(1, 1); tick(1); tick(0);
    vectors++; if (overloadDrive !== 1'b1) begin miscompares++; $display("FAIL t3_flag_start: got %b want 1", overloadDrive); end
    for (int i = 0; i < 6; i++) begin
      tick(0);
      vectors++; if (overloadDrive !== (i < 5)) begin miscompares++; $display("FAIL t3_flag i=%0d: got %b want %b", i, overloadDrive, i < 5); end
    end
    tick(0); tick(0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      vectors++; if (endOverload !== (i == 7)) begin miscompares++; $display("FAIL t3_delim i=%0d: got %b want %b", i, endOverload, i == 7); end
      vectors++; if (obs !== exp) begin miscompares++; $display("FAIL t3_model i=%0d: got %b want %b", i, obs, exp); end
    end
    vectors++; if (overloadCount !== 4'd1) begin miscompares++; $display("FAIL t3_count: got %0d want 1", overloadCount); end
    for (int i = 0; i < 3; i++) tick(1);
    vectors++; if (busIdle !== 1'b1 || overloadCount !== 4'd0) begin miscompares++; $display("FAIL t3_back_idle: got idle=%b cnt=%0d want 1 0", busIdle, overloadCount); end
  endtask

  task automatic test_overload_limit();
    tick(0); tick(1, 1);
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 0, 0, 1);
      if (k < 2) begin
        for (int i = 0; i < 6; i++) tick(0);
        for (int i = 0; i < 8; i++) tick(1);
        vectors++; if (endOverload !== 1'b1 || overloadCount !== 4'(k + 1)) begin miscompares++; $display("FAIL t4_ovl k=%0d: got end=%b cnt=%0d want 1 %0d", k, endOverload, overloadCount, k + 1); end
      end else begin
        vectors++; if (formError !== 1'b1 || overloadCount !== 4'd2 || overloadDrive !== 1'b0) begin miscompares++; $display("FAIL t4_limit: got ferr=%b cnt=%0d drive=%b want 1 2 0", formError, overloadCount, overloadDrive); end
      end
      vectors++; if (obs !== exp) begin miscompares++; $display("FAIL t4_model k=%0d: got %b want %b", k, obs, exp); end
    end
    for (int i = 0; i < 4; i++) tick(1);
    vectors++; if (formError !== 1'b0 || busIdle !== 1'b0) begin miscompares++; $display("FAIL t4_err_wait: got ferr=%b idle=%b want 0 0", formError, busIdle); end
    tick(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1);
    vectors++; if (busIdle !== 1'b1 || overloadCount !== 4'd0) begin miscompares++; $display("FAIL t4_recover: got idle=%b cnt=%0d want 1 0", busIdle, overloadCount); end
  endtask

  task automatic test_suspend();
    errorPassive = 1;
    wasTransmitter = 1;
    tick(0); tick(1, 1);
    for (int i = 0; i < 3; i++) tick(1);
    vectors++; if (busIdle !== 1'b0) begin miscompares++; $display("FAIL t5_suspend_entry: got idle=%b want 0", busIdle); end
    for (int i = 0; i < 4; i++) tick(1);
    tick(0);
    vectors++; if (isStart !== 1'b1) begin miscompares++; $display("FAIL t5_suspend_sof: got %b want 1", isStart); end
    tick(1, 1);
    for (int i = 0; i < 11; i++) begin
      tick(1);
      vectors++; if (busIdle !== (i == 10)) begin miscompares++; $display("FAIL t5_suspend_idle i=%0d: got %b want %b", i, busIdle, i == 10); end
    end
    errorPassive = 0;
    wasTransmitter = 0;
  endtask

  task automatic test_back_to_back();
    tick(0); tick(1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vectors++; if (busIdle !== 1'b0 || obs !== exp) begin miscompares++; $display("FAIL t6_err_priority i=%0d: got %b want %b", i, obs, exp); end
    end
    tick(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1);
    vectors++; if (busIdle !== 1'b1) begin miscompares++; $display("FAIL t6_err_recover: got %b want 1", busIdle); end
    tick(0); tick(1, 1); tick(0); tick(0);
    vectors++; if (overloadDrive !== 1'b1) begin miscompares++; $display("FAIL t6_flag: got %b want 1", overloadDrive); end
    reset = 1;
    tick(0);
    vectors++; if (obs !== 9'b0) begin miscompares++; $display("FAIL t6_reset_flag: got %b want 000000000", obs); end
    reset = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      int bias;
      bias = ((i / 200) % 2) != 0 ? 9 : 5;
      reset = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 63) == 0) begin
        errorPassive = 1'($urandom_range(0, 1));
        wasTransmitter = 1'($urandom_range(0, 1));
      end
      tick($urandom_range(0, 9) < bias, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      vectors++; if (obs !== exp) begin miscompares++; $display("FAIL random i=%0d: got %b want %b", i, obs, exp); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_sof_idle();
    test_overload();
    test_overload_limit();
    test_suspend();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
